// File: rtl/param_reg_file.sv
// -----------------------------------------------------------------------------
// param_reg_file
//
// Parametrised register file: DEPTH = 2**ADDR_W entries of DATA_W bits, with
// two read ports, one monitor read port and one strobe-qualified write port.
// A sequenced clear engine walks the array one entry per cycle and reports
// Busy while it runs; writes issued while Busy are dropped and flagged.
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write that commits on the coming edge is
//                      forwarded combinationally to any read port whose address
//                      matches Write_Reg. When undefined, reads return the
//                      stored value until the edge.
//
// Ports:
//   CLK, RST_N           clock (rising edge) and asynchronous active-low reset
//   Write_Strobe         write-phase qualifier from the control FSM
//   RegWrite             write enable, effective only with Write_Strobe
//   Write_Reg            write address
//   Reg_Write_Data       write data
//   Read_Reg1/Read_Reg2  read port addresses
//   Reg_Data_Select      monitor port address
//   Clr_Start            request a sequential clear of all entries
//   Read_Data1/2         read port data (combinational)
//   Reg_Data             monitor port data (combinational)
//   Reg_Write_Data_Save  last data presented on a strobe
//   Busy                 clear engine active
//   Write_Drop           one-cycle pulse: a write was rejected while Busy
// -----------------------------------------------------------------------------
module param_reg_file #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              Write_Strobe,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] Write_Reg,
   input  logic [DATA_W-1:0] Reg_Write_Data,
   input  logic [ADDR_W-1:0] Read_Reg1,
   input  logic [ADDR_W-1:0] Read_Reg2,
   input  logic [ADDR_W-1:0] Reg_Data_Select,
   input  logic              Clr_Start,
   output logic [DATA_W-1:0] Read_Data1,
   output logic [DATA_W-1:0] Read_Data2,
   output logic [DATA_W-1:0] Reg_Data,
   output logic [DATA_W-1:0] Reg_Write_Data_Save,
   output logic              Busy,
   output logic              Write_Drop
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] save_q,  save_d;
   logic              drop_q,  drop_d;

   logic busy;
   logic wr_req;
   logic wr_commit;

   assign busy      = (state_q == ST_CLEAR);
   assign wr_req    = Write_Strobe & RegWrite;
   // A write accepted on the same edge as Clr_Start still commits because the
   // engine only becomes Busy after that edge.
   assign wr_commit = wr_req & ~busy;

   // ---------------------------------------------------------------------------
   // Clear engine next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            // idx_q is already 0 here: it is reset to 0 and wraps to 0 on exit.
            if (Clr_Start) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // Clr_Start is deliberately ignored here: no restart, no extension.
            if (idx_q == '1) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Array, capture register and drop flag next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      // A commit and a clear never coincide: commits need !busy, clears need busy.
      if (wr_commit) begin
         mem_d[Write_Reg] = Reg_Write_Data;
      end
      if (busy) begin
         mem_d[idx_q] = '0;
      end
   end

   always_comb begin
      // The capture register follows every strobe, even rejected or save-only ones.
      save_d = Write_Strobe ? Reg_Write_Data : save_q;
      drop_d = wr_req & busy;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         save_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         save_q  <= save_d;
         drop_q  <= drop_d;
      end
   end

   // NOTE: the array is built from flops with asynchronous reset because every
   // entry must read 0 immediately on reset, including a reset that aborts a
   // clear in progress; a RAM macro could not provide that.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_BYPASS_EN
      // Forward the data that will be stored on the coming edge.
      if (wr_commit && (addr == Write_Reg)) begin
         return Reg_Write_Data;
      end
`endif
      return mem_q[addr];
   endfunction

   always_comb begin
      Read_Data1 = read_port(Read_Reg1);
      Read_Data2 = read_port(Read_Reg2);
      Reg_Data   = read_port(Reg_Data_Select);
   end

   assign Reg_Write_Data_Save = save_q;
   assign Busy                = busy;
   assign Write_Drop          = drop_q;

endmodule

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic              CLK;
   logic              RST_N;
   logic              Write_Strobe;
   logic              RegWrite;
   logic [ADDR_W-1:0] Write_Reg;
   logic [DATA_W-1:0] Reg_Write_Data;
   logic [ADDR_W-1:0] Read_Reg1;
   logic [ADDR_W-1:0] Read_Reg2;
   logic [ADDR_W-1:0] Reg_Data_Select;
   logic              Clr_Start;
   logic [DATA_W-1:0] Read_Data1;
   logic [DATA_W-1:0] Read_Data2;
   logic [DATA_W-1:0] Reg_Data;
   logic [DATA_W-1:0] Reg_Write_Data_Save;
   logic              Busy;
   logic              Write_Drop;

   int checks = 0;
   int errors = 0;

   param_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .CLK                 (CLK),
      .RST_N               (RST_N),
      .Write_Strobe        (Write_Strobe),
      .RegWrite            (RegWrite),
      .Write_Reg           (Write_Reg),
      .Reg_Write_Data      (Reg_Write_Data),
      .Read_Reg1           (Read_Reg1),
      .Read_Reg2           (Read_Reg2),
      .Reg_Data_Select     (Reg_Data_Select),
      .Clr_Start           (Clr_Start),
      .Read_Data1          (Read_Data1),
      .Read_Data2          (Read_Data2),
      .Reg_Data            (Reg_Data),
      .Reg_Write_Data_Save (Reg_Write_Data_Save),
      .Busy                (Busy),
      .Write_Drop          (Write_Drop)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: contents array, capture value, and a count of clear
   // cycles still to run. The clear walks entries 0..DEPTH-1 in order.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [DATA_W-1:0] m_save;
   int                m_left;
   logic              m_drop;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_save = '0;
         m_left = 0;
         m_drop = 1'b0;
      end else begin
         m_drop = Write_Strobe && RegWrite && (m_left != 0);
         if (Write_Strobe) m_save = Reg_Write_Data;
         if (m_left != 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left = m_left - 1;
         end else begin
            if (Write_Strobe && RegWrite) m_mem[Write_Reg] = Reg_Write_Data;
            if (Clr_Start) m_left = DEPTH;
         end
      end
   end

   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_BYPASS_EN
      if (Write_Strobe && RegWrite && (m_left == 0) && (addr == Write_Reg))
         return Reg_Write_Data;
`endif
      return m_mem[addr];
   endfunction

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge CLK) begin
      check("cmp_rd1",  Read_Data1,          exp_read(Read_Reg1));
      check("cmp_rd2",  Read_Data2,          exp_read(Read_Reg2));
      check("cmp_mon",  Reg_Data,            exp_read(Reg_Data_Select));
      check("cmp_save", Reg_Write_Data_Save, m_save);
      check("cmp_busy", Busy,                (m_left != 0));
      check("cmp_drop", Write_Drop,          m_drop);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      Write_Strobe   = 1'b1;
      RegWrite       = 1'b1;
      Write_Reg      = a;
      Reg_Write_Data = d;
      tick();
      Write_Strobe   = 1'b0;
      RegWrite       = 1'b0;
   endtask

   task automatic set_reads(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                            input logic [ADDR_W-1:0] am);
      Read_Reg1       = a1;
      Read_Reg2       = a2;
      Reg_Data_Select = am;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [DATA_W-1:0] pre_val;

      RST_N = 1'b0;
      Write_Strobe = 1'b0; RegWrite = 1'b0; Write_Reg = '0; Reg_Write_Data = '0;
      Read_Reg1 = '0; Read_Reg2 = '0; Reg_Data_Select = '0; Clr_Start = 1'b0;

      // Reset then read all.
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         set_reads(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a), ADDR_W'(a));
         check("rst_rd1", Read_Data1, 8'h00);
         check("rst_rd2", Read_Data2, 8'h00);
         check("rst_mon", Reg_Data,   8'h00);
      end
      check("rst_busy", Busy, 1'b0);
      check("rst_save", Reg_Write_Data_Save, 8'h00);
      check("rst_drop", Write_Drop, 1'b0);

      // Basic write/read.
      do_write(2'd2, 8'hA5);
      do_write(2'd1, 8'h3C);
      set_reads(2'd2, 2'd1, 2'd2);
      check("wr_rd1", Read_Data1, 8'hA5);
      check("wr_rd2", Read_Data2, 8'h3C);
      check("wr_mon", Reg_Data,   8'hA5);

      // Save-only strobe.
      Write_Strobe = 1'b1; RegWrite = 1'b0; Write_Reg = 2'd2; Reg_Write_Data = 8'h77;
      tick();
      Write_Strobe = 1'b0;
      set_reads(2'd2, 2'd1, 2'd0);
      check("save_only_save", Reg_Write_Data_Save, 8'h77);
      check("save_only_r2",   Read_Data1, 8'hA5);
      check("save_only_r1",   Read_Data2, 8'h3C);
      check("save_only_r0",   Reg_Data,   8'h00);

      // Sequential clear with a colliding write and a second start.
      do_write(2'd0, 8'h11);
      do_write(2'd1, 8'h22);
      do_write(2'd2, 8'h33);
      do_write(2'd3, 8'h44);
      Clr_Start = 1'b1;
      tick();
      Clr_Start = 1'b0;
      n = 0;
      while (Busy === 1'b1 && n < 20) begin
         n++;
         case (n)
            1: begin
               Write_Strobe = 1'b1; RegWrite = 1'b1;
               Write_Reg = 2'd3; Reg_Write_Data = 8'h99;
               Clr_Start = 1'b1;
            end
            2: begin
               Write_Strobe = 1'b0; RegWrite = 1'b0; Clr_Start = 1'b0;
               #1;
               check("clr_drop_pulse", Write_Drop, 1'b1);
               check("clr_drop_save",  Reg_Write_Data_Save, 8'h99);
            end
            3: begin
               set_reads(2'd0, 2'd1, 2'd2);
               check("clr_drop_end", Write_Drop, 1'b0);
               check("clr_reg0",     Read_Data1, 8'h00);
               check("clr_reg1",     Read_Data2, 8'h00);
               check("clr_reg2",     Reg_Data,   8'h33);
            end
            default: ;
         endcase
         tick();
      end
      check("clr_busy_len", n, 4);
      set_reads(2'd2, 2'd1, 2'd3);
      check("clr_done_busy", Busy, 1'b0);
      check("clr_reg3_end",  Reg_Data, 8'h00);
      check("clr_reg2_end",  Read_Data1, 8'h00);

      // Reset mid-clear.
      do_write(2'd2, 8'h12);
      Clr_Start = 1'b1;
      tick();
      Clr_Start = 1'b0;
      tick();
      set_reads(2'd2, 2'd1, 2'd3);
      check("midclr_busy_before", Busy, 1'b1);
      check("midclr_reg2_before", Read_Data1, 8'h12);
      RST_N = 1'b0;
      #1;
      check("midclr_busy", Busy, 1'b0);
      check("midclr_reg2", Read_Data1, 8'h00);
      check("midclr_save", Reg_Write_Data_Save, 8'h00);
      tick();
      RST_N = 1'b1;
      do_write(2'd0, 8'h5A);
      set_reads(2'd0, 2'd2, 2'd0);
      check("post_rst_wr",   Read_Data1, 8'h5A);
      check("post_rst_busy", Busy, 1'b0);

      // Same-cycle write/read of one address.
      do_write(2'd1, 8'h10);
      set_reads(2'd1, 2'd0, 2'd1);
      Write_Strobe = 1'b1; RegWrite = 1'b1; Write_Reg = 2'd1; Reg_Write_Data = 8'hF0;
      #1;
`ifdef REGFILE_BYPASS_EN
      pre_val = 8'hF0;
`else
      pre_val = 8'h10;
`endif
      check("byp_rd1_pre", Read_Data1, pre_val);
      check("byp_mon_pre", Reg_Data,   pre_val);
      check("byp_rd2_pre", Read_Data2, 8'h5A);
      tick();
      Write_Strobe = 1'b0; RegWrite = 1'b0;
      #1;
      check("byp_rd1_post", Read_Data1, 8'hF0);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
